uart_sync_fifo: RTL and testbench
=================================

// Module: uart_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO buffering UART TX/RX bytes between the bus side and the shift engines.
//  Generalises the 8x8 byte FIFO: configurable width and depth, true full at DEPTH entries, concurrent read+write,
//  occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow, synchronous flush.
// PARAMETERS
//  DATA_W   8  data width in bits
//  DEPTH    16 entries; power of 2, >=4
//  AW       $clog2(DEPTH) pointer width (derived, localparam)
//  AF_LVL   DEPTH-2  almost_full asserts when count >= AF_LVL
//  AE_LVL   2  almost_empty asserts when count <= AE_LVL
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       asynchronous reset, active-low (asserts on low, released synchronously by source)
//  clr          in   1       synchronous flush, active-high
//  wr           in   1       write request
//  datain       in   DATA_W  write data, sampled when wr accepted
//  rd           in   1       read request
//  dataout      out  DATA_W  read data, registered
//  rd_valid     out  1       1-cycle pulse: dataout updated by accepted read
//  full         out  1       count == DEPTH
//  emp          out  1       count == 0
//  almost_full  out  1       count >= AF_LVL
//  almost_empty out  1       count <= AE_LVL
//  count        out  AW+1    current occupancy 0..DEPTH
//  overflow     out  1       sticky: write attempted while full
//  underflow    out  1       sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=0): wr_ptr=rd_ptr=0, count=0, dataout=0, rd_valid=0, overflow=underflow=0; emp=1, full=0,
//    almost_empty=1, almost_full=0. Memory array not reset. Reset mid-operation discards all contents immediately.
//  - Pointers AW+1 bits (wrap bit); full = MSBs differ & low bits equal; emp = pointers equal. count = wr_ptr-rd_ptr.
//  - Write accepted iff wr && !full: mem[wr_ptr[AW-1:0]] <= datain; wr_ptr++ (modulo 2*DEPTH).
//  - Read accepted iff rd && !emp: dataout <= mem[rd_ptr[AW-1:0]]; rd_ptr++; rd_valid=1 next cycle.
//    Read latency 1 clk. When no read accepted, dataout holds last value, rd_valid=0.
//  - Flags decided on registered state at the edge (no combinational look-ahead):
//    both wr&rd, 0<count<DEPTH: both accepted, count unchanged.
//    both wr&rd, emp: write only (no bypass), underflow set, rd_valid=0.
//    both wr&rd, full: read only, overflow set; written word lost.
//  - overflow/underflow: set on rejected request, hold until clr or reset.
//  - clr=1: pointers, count, overflow, underflow, rd_valid -> 0 next edge; dataout holds; wr/rd ignored that cycle.
//    clr has priority over wr/rd.
//  - Flags/count are combinational from registered pointers; valid cycle after the edge that changed them.
//  - No state machine beyond pointers; all outputs glitch-free w.r.t. clk (derived only from flops).
// TESTING (DATA_W=8, DEPTH=8, AF_LVL=6, AE_LVL=2)
//  1 Reset: drive rst=0 mid-traffic with count=5 -> next sample count=0, emp=1, dataout=0, rd_valid=0.
//  2 Fill: write 0x01..0x08 -> full=1 after 8th, count=8, almost_full from 6th; 9th write 0xAA -> overflow=1, count=8.
//  3 Drain: read 8x -> dataout 0x01..0x08 in order, each 1 clk after rd, rd_valid pulses; 9th rd -> underflow=1, rd_valid=0.
//  4 Wrap: 20 rounds write 3/read 3 of incrementing data -> order preserved across pointer wrap, no flags set.
//  5 Concurrent: count=4, wr+rd 10 cycles -> count stays 4, data FIFO order; at emp wr+rd -> count=1, underflow=1;
//    at full wr+rd -> count=7, overflow=1.
//  6 Flush: count=5, overflow=1, clr=1 with wr=1 -> count=0, emp=1, overflow=0, written word dropped.

Source files
------------

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO that buffers UART TX/RX bytes between the bus side and
//   the shift engines. It has a configurable width and depth and holds a full
//   DEPTH entries. It accepts a read and a write in the same cycle, reports its
//   occupancy count and programmable almost-full / almost-empty flags, keeps
//   sticky overflow / underflow flags, and has a synchronous flush.
//
//   Ports
//     clk          : clock; all logic updates on the rising edge
//     rst          : asynchronous reset, active-low
//     clr          : synchronous flush, active-high; overrides wr/rd
//     wr, datain   : write request and write data
//     rd           : read request
//     dataout      : registered read data; holds its value when idle
//     rd_valid     : one-cycle pulse when dataout was updated by a read
//     full, emp    : count == DEPTH / count == 0
//     almost_full  : count >= AF_LVL
//     almost_empty : count <= AE_LVL
//     count        : occupancy, 0..DEPTH
//     overflow     : sticky, a write was attempted while full
//     underflow    : sticky, a read was attempted while empty
//
//   Handshake: wr and rd are requests sampled on the rising edge. A write is
//   accepted only when the FIFO is not full, and a read only when it is not
//   empty, judged on the registered state before that edge. A rejected request
//   sets the matching sticky flag. Read data appears one cycle after the edge
//   that accepted the read, together with rd_valid.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        datain,
  input  logic                     rd,
  output logic [DATA_W-1:0]        dataout,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     emp,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_LVL);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  // The pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AW:0]        wr_ptr_q,    wr_ptr_d;
  logic [AW:0]        rd_ptr_q,    rd_ptr_d;
  logic [DATA_W-1:0]  dataout_q,   dataout_d;
  logic               rd_valid_q,  rd_valid_d;
  logic               overflow_q,  overflow_d;
  logic               underflow_q, underflow_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic full_w, emp_w, wr_acc, rd_acc;

  // The flags come only from the registered pointers, so they change
  // cleanly on the clock and never depend on this cycle's requests.
  assign emp_w  = (wr_ptr_q == rd_ptr_q);
  assign full_w = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_acc = wr && !full_w && !clr;
  assign rd_acc = rd && !emp_w  && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dataout_d   = dataout_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      // The flush leaves dataout alone so the last byte read stays visible.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ONE;
        dataout_d  = mem_q[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
      end
      // When the FIFO is empty, a write in the same cycle does not bypass
      // to the read, so the read is rejected.
      if (wr && full_w) overflow_d  = 1'b1;
      if (rd && emp_w)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dataout_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dataout_q   <= dataout_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The storage is not reset. Clearing the pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= datain;
  end

  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = full_w;
  assign emp          = emp_w;
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign dataout      = dataout_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_sync_fifo
//   Self-checking bench for uart_sync_fifo configured with DATA_W=8, DEPTH=8,
//   AF_LVL=6 and AE_LVL=2. A queue-based reference model of the FIFO rules runs
//   next to the DUT. A fill/drain vector table and hand-written corner
//   sequences add fixed expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_uart_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = 6;
  localparam int AE_LVL = 2;

  // ---------------- clock / reset ----------------
  logic clk, rst, clr, wr, rd;
  logic [DATA_W-1:0] datain, dataout;
  logic rd_valid, full, emp, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .datain(datain), .rd(rd),
    .dataout(dataout), .rd_valid(rd_valid), .full(full), .emp(emp),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_dout;
  logic m_rv, m_ovf, m_unf;
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock edge of the FIFO rules, applied to the queue.
  task automatic model_edge(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    int sz;
    sz = exp_q.size();
    m_rv = 1'b0;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (r && sz > 0) begin
        m_dout = exp_q.pop_front();
        m_rv   = 1'b1;
      end
      if (w && sz < DEPTH) exp_q.push_back(d);
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ".count"},        32'(count),        32'(sz));
    chk({tag, ".full"},         32'(full),         32'(sz == DEPTH));
    chk({tag, ".emp"},          32'(emp),          32'(sz == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF_LVL));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE_LVL));
    chk({tag, ".dataout"},      32'(dataout),      32'(m_dout));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rv));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 ns after a rising edge. The step drives them, waits
  // for the next edge, and samples the DUT 1 ns after that edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                      input logic c, input string tag);
    wr = w; datain = d; rd = r; clr = c;
    @(posedge clk);
    #1;
    model_edge(w, d, r, c);
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    check_model(tag);
  endtask

  // ---------------- fill/drain vector table ----------------
  typedef struct {
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] din;
    int                e_count;
    logic              e_full;
    logic              e_emp;
    logic              e_af;
    logic              e_ae;
    logic [DATA_W-1:0] e_dout;
    logic              e_rv;
    logic              e_ovf;
    logic              e_unf;
  } vec_t;

  vec_t vt[18];

  task automatic build_table();
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{wr:1'b1, rd:1'b0, din:8'(i+1), e_count:i+1, e_full:(i == 7), e_emp:1'b0,
                e_af:(i+1 >= 6), e_ae:(i+1 <= 2), e_dout:8'h00, e_rv:1'b0, e_ovf:1'b0, e_unf:1'b0};
    end
    vt[8] = '{wr:1'b1, rd:1'b0, din:8'hAA, e_count:8, e_full:1'b1, e_emp:1'b0,
              e_af:1'b1, e_ae:1'b0, e_dout:8'h00, e_rv:1'b0, e_ovf:1'b1, e_unf:1'b0};
    for (int j = 0; j < 8; j++) begin
      vt[9+j] = '{wr:1'b0, rd:1'b1, din:8'h00, e_count:7-j, e_full:1'b0, e_emp:(j == 7),
                  e_af:(7-j >= 6), e_ae:(7-j <= 2), e_dout:8'(j+1), e_rv:1'b1,
                  e_ovf:1'b1, e_unf:1'b0};
    end
    vt[17] = '{wr:1'b0, rd:1'b1, din:8'h00, e_count:0, e_full:1'b0, e_emp:1'b1,
               e_af:1'b0, e_ae:1'b1, e_dout:8'h08, e_rv:1'b0, e_ovf:1'b1, e_unf:1'b1};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] dv;
    int p_wr;
    logic w, r, c;

    rst = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; datain = '0;
    model_reset();
    build_table();

    // Reset state
    #3;
    check_model("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    check_model("reset_release");

    // Fill then drain, compared against the table and the model
    for (int k = 0; k < 18; k++) begin
      step(vt[k].wr, vt[k].din, vt[k].rd, 1'b0, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.count", k),     32'(count),     32'(vt[k].e_count));
      chk($sformatf("tbl%0d.full", k),      32'(full),      32'(vt[k].e_full));
      chk($sformatf("tbl%0d.emp", k),       32'(emp),       32'(vt[k].e_emp));
      chk($sformatf("tbl%0d.af", k),        32'(almost_full),  32'(vt[k].e_af));
      chk($sformatf("tbl%0d.ae", k),        32'(almost_empty), 32'(vt[k].e_ae));
      chk($sformatf("tbl%0d.dout", k),      32'(dataout),   32'(vt[k].e_dout));
      chk($sformatf("tbl%0d.rv", k),        32'(rd_valid),  32'(vt[k].e_rv));
      chk($sformatf("tbl%0d.ovf", k),       32'(overflow),  32'(vt[k].e_ovf));
      chk($sformatf("tbl%0d.unf", k),       32'(underflow), 32'(vt[k].e_unf));
    end

    // Flush clears the sticky flags and leaves dataout unchanged
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_after_drain");
    chk("clr_after_drain.dout_hold", 32'(dataout), 32'h08);

    // Wrap: 20 rounds of write 3 / read 3
    dv = 8'h10;
    for (int rnd = 0; rnd < 20; rnd++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, dv, 1'b0, 1'b0, "wrap_wr");
        dv = dv + 8'd1;
      end
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_rd");
    end
    chk("wrap.ovf", 32'(overflow), 32'h0);
    chk("wrap.unf", 32'(underflow), 32'h0);

    // Concurrent read and write at count=4
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, "conc_fill");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 8'(8'h50 + k), 1'b1, 1'b0, "conc_both");
      chk("conc_both.count4", 32'(count), 32'd4);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0, "conc_drain");
    step(1'b1, 8'h77, 1'b1, 1'b0, "both_at_emp");
    chk("both_at_emp.count", 32'(count), 32'd1);
    chk("both_at_emp.unf", 32'(underflow), 32'd1);
    chk("both_at_emp.rv", 32'(rd_valid), 32'd0);
    for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h60 + k), 1'b0, 1'b0, "to_full");
    step(1'b1, 8'hEE, 1'b1, 1'b0, "both_at_full");
    chk("both_at_full.count", 32'(count), 32'd7);
    chk("both_at_full.ovf", 32'(overflow), 32'd1);
    chk("both_at_full.dout", 32'(dataout), 32'h77);

    // Flush with a simultaneous write, starting from count=5 with overflow set
    step(1'b0, 8'h00, 1'b0, 1'b1, "flush_pre");
    for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0, "flush_fill");
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0, "flush_rd");
    chk("flush_setup.count", 32'(count), 32'd5);
    chk("flush_setup.ovf", 32'(overflow), 32'd1);
    step(1'b1, 8'hCC, 1'b0, 1'b1, "flush");
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.emp", 32'(emp), 32'd1);
    chk("flush.ovf", 32'(overflow), 32'd0);
    chk("flush.dout_hold", 32'(dataout), 32'h82);
    step(1'b1, 8'h33, 1'b0, 1'b0, "post_flush_wr");
    step(1'b0, 8'h00, 1'b1, 1'b0, "post_flush_rd");
    chk("post_flush.dout", 32'(dataout), 32'h33);

    // Randomized traffic with phases biased toward filling or draining
    for (int i = 0; i < 600; i++) begin
      p_wr = ((i / 60) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(99, 0) < p_wr);
      r  = ($urandom_range(99, 0) < (100 - p_wr));
      c  = ($urandom_range(79, 0) == 0);
      dv = 8'($urandom);
      step(w, dv, r, c, "rand");
    end

    // Reset asserted mid-traffic at count=5
    step(1'b0, 8'h00, 1'b0, 1'b1, "mid_pre");
    for (int k = 0; k < 6; k++) step(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, "mid_fill");
    step(1'b0, 8'h00, 1'b1, 1'b0, "mid_rd");
    chk("mid.count5", 32'(count), 32'd5);
    wr = 1'b1; rd = 1'b1; datain = 8'h5A;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model("mid_reset");
    wr = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    check_model("mid_reset_held");
    rst = 1'b1;
    step(1'b1, 8'h11, 1'b0, 1'b0, "after_rst_wr");
    step(1'b0, 8'h00, 1'b1, 1'b0, "after_rst_rd");
    chk("after_rst.dout", 32'(dataout), 32'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
